// File: rtl/mux_sched_pkg.sv
// Shared constants, state type and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  function automatic logic [N_CH-1:0] onehot16(input logic [SEL_W-1:0] idx);
    logic [N_CH-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux16to1.sv
// Plain 16-to-1 bit multiplexer shared by all channels.
module mux16to1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set bit of vec scanning upward from start, wrapping 15 -> 0.
module rr_pick16
  import mux_sched_pkg::*;
(
  input  logic [N_CH-1:0]  vec,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Offsets are added in SEL_W-bit arithmetic so the scan position wraps for free.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && vec[start + SEL_W'(i)]) begin
        found = 1'b1;
        idx   = start + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler that owns the 16-to-1 mux select, bounds each contended grant to MAX_HOLD cycles and registers the muxed bit.
module mux16_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  in,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  gnt,
  output logic             gnt_valid,
  output logic             out
);

  localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       hold_q, hold_d;
  logic             out_q, out_d;

  logic [N_CH-1:0]  others;
  logic [SEL_W-1:0] nextPtr;
  logic             idleFound, nextFound;
  logic [SEL_W-1:0] idleIdx, nextIdx;
  logic             muxOut;

  assign others  = req & ~onehot16(sel_q);
  assign nextPtr = sel_q + SEL_W'(1);

  rr_pick16 u_pickIdle (
    .vec   (req),
    .start (ptr_q),
    .found (idleFound),
    .idx   (idleIdx)
  );

  // On release the search starts just past the current owner, which is also the new pointer.
  rr_pick16 u_pickNext (
    .vec   (others),
    .start (nextPtr),
    .found (nextFound),
    .idx   (nextIdx)
  );

  mux16to1 u_mux (
    .in  (in),
    .sel (sel_q),
    .out (muxOut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    out_d   = (state_q == GRANT) ? muxOut : out_q;
    unique case (state_q)
      IDLE: begin
        if (idleFound) begin
          state_d = GRANT;
          sel_d   = idleIdx;
          hold_d  = 4'd1;
        end
      end
      GRANT: begin
        // A lone requester may keep the mux indefinitely; hold_q just saturates.
        if (req[sel_q] && ((hold_q < HoldMax) || (others == '0))) begin
          if (hold_q < HoldMax) begin
            hold_d = hold_q + 4'd1;
          end
        end else begin
          ptr_d = nextPtr;
          if (nextFound) begin
            sel_d  = nextIdx;
            hold_d = 4'd1;
          end else begin
            state_d = IDLE;
            hold_d  = 4'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_valid = (state_q == GRANT);
    gnt       = gnt_valid ? onehot16(sel_q) : '0;
    sel       = sel_q;
    out       = out_q;
  end

endmodule
